// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, fixed latency,
// RV32I byte/halfword/word access with fault reporting.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | latency down-counter running
// RESP  | response presented, held until rsp_ready
module dmem_responder #(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic        accept, commit;

    logic        lat_write;
    logic [2:0]  lat_funct3;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic [31:0] mem [DEPTH];

    logic        misaligned, bad_funct3, out_of_range, fault;
    logic [IW-1:0] idx;
    logic [3:0]  be;
    logic [31:0] wlane;
    logic [31:0] rword, shifted, load_val;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // LATENCY=1 still passes through WAIT once (counter 0), so rsp_valid always
    // rises LATENCY edges after the accept edge.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bad_funct3   = lat_write ? (lat_funct3 > 3'd2)
                                 : (lat_funct3 == 3'd3 || lat_funct3 >= 3'd6);
        misaligned   = (lat_funct3[1:0] == 2'b01 && lat_addr[0]) ||
                       (lat_funct3[1:0] == 2'b10 && lat_addr[1:0] != 2'b00);
        out_of_range = lat_addr[31:2] >= 30'(DEPTH);
        fault        = bad_funct3 || misaligned || out_of_range;
        idx          = lat_addr[IW+1:2];
    end

    always_comb begin
        be    = 4'b1111;
        wlane = lat_wdata;
        case (lat_funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << lat_addr[1:0];
                wlane = {4{lat_wdata[7:0]}};
            end
            2'b01: begin
                be    = lat_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{lat_wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = lat_wdata;
            end
        endcase
    end

    always_comb begin
        rword    = mem[idx];
        shifted  = rword >> {lat_addr[1:0], 3'b000};
        load_val = 32'h0;
        case (lat_funct3)
            3'd0:    load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'd2:    load_val = rword;
            3'd4:    load_val = {24'h0, shifted[7:0]};
            3'd5:    load_val = {16'h0, shifted[15:0]};
            default: load_val = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (commit) begin
                rsp_valid <= 1'b1;
                rsp_err   <= fault;
                rsp_rdata <= (fault || lat_write) ? 32'h0 : load_val;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_rdata <= 32'h0;
                rsp_err   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write  <= req_write;
            lat_funct3 <= req_funct3;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && commit && lat_write && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (LATENCY 2, 3, 1)
// share request fields; each has its own req_valid and outputs.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    logic        req_valid_a [3];
    logic        req_ready_a [3];
    logic        rsp_valid_a [3];
    logic [31:0] rsp_rdata_a [3];
    logic        rsp_err_a   [3];

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(512), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]),
        .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a[0]), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_a[0]), .rsp_err(rsp_err_a[0])
    );

    dmem_responder #(.DEPTH(512), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]),
        .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a[1]), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_a[1]), .rsp_err(rsp_err_a[1])
    );

    dmem_responder #(.DEPTH(512), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a[2]), .req_ready(req_ready_a[2]),
        .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a[2]), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_a[2]), .rsp_err(rsp_err_a[2])
    );

    function automatic vec_t mk(logic wr, logic [2:0] f3, logic [31:0] a,
                                logic [31:0] wd, logic [31:0] rd, logic er);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd; v.err = er;
        return v;
    endfunction

    // Drives one request to instance k, scrambles the request fields after the
    // accept edge, and returns edges-to-rsp_valid plus the response. Completes
    // the response handshake only if rsp_ready is high.
    task automatic drive_access(input int k, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output int lat, output logic [31:0] rdata,
                                output logic err);
        int n;
        @(negedge clk);
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid_a[k] = 1'b1;
        n = 0;
        while (req_ready_a[k] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid_a[k] = 1'b0;
        req_write  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        lat = 0;
        while (rsp_valid_a[k] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = rsp_rdata_a[k];
        err   = rsp_err_a[k];
        if (rsp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rsp_ready = 1'b1;
        req_write = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        for (int k = 0; k < 3; k++) req_valid_a[k] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (req_ready_a[k] !== 1'b0) begin
                errors++; $display("FAIL reset_req_ready[%0d]: got %b expected 0", k, req_ready_a[k]);
            end
            checks++;
            if (rsp_valid_a[k] !== 1'b0) begin
                errors++; $display("FAIL reset_rsp_valid[%0d]: got %b expected 0", k, rsp_valid_a[k]);
            end
            checks++;
            if (rsp_rdata_a[k] !== 32'h0) begin
                errors++; $display("FAIL reset_rsp_rdata[%0d]: got %h expected 0", k, rsp_rdata_a[k]);
            end
            checks++;
            if (rsp_err_a[k] !== 1'b0) begin
                errors++; $display("FAIL reset_rsp_err[%0d]: got %b expected 0", k, rsp_err_a[k]);
            end
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (req_ready_a[k] !== 1'b1) begin
                errors++; $display("FAIL post_reset_req_ready[%0d]: got %b expected 1", k, req_ready_a[k]);
            end
        end
    endtask

    task automatic test_load_store();
        vec_t tbl [$];
        exp_t e;
        int lat;
        logic [31:0] rd;
        logic er;
        tbl.push_back(mk(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0));
        tbl.push_back(mk(1'b1, 3'd0, 32'h11, 32'h000000AA, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0));
        tbl.push_back(mk(1'b0, 3'd0, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0));
        tbl.push_back(mk(1'b0, 3'd4, 32'h11, 32'h0, 32'h000000AA, 1'b0));
        tbl.push_back(mk(1'b0, 3'd0, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0));
        tbl.push_back(mk(1'b0, 3'd1, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0));
        tbl.push_back(mk(1'b0, 3'd5, 32'h12, 32'h0, 32'h0000DEAD, 1'b0));
        tbl.push_back(mk(1'b1, 3'd1, 32'h12, 32'h5555CAFE, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0, 32'hCAFEAAEF, 1'b0));
        tbl.push_back(mk(1'b0, 3'd4, 32'h13, 32'h0, 32'h000000CA, 1'b0));
        foreach (tbl[i]) begin
            e.rdata = tbl[i].rdata;
            e.err   = tbl[i].err;
            sb.push_back(e);
            drive_access(0, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata, lat, rd, er);
            e = sb.pop_front();
            checks++;
            if (lat !== 2) begin
                errors++; $display("FAIL ls_latency[%0d]: got %0d expected 2", i, lat);
            end
            checks++;
            if (rd !== e.rdata) begin
                errors++; $display("FAIL ls_rdata[%0d]: got %h expected %h", i, rd, e.rdata);
            end
            checks++;
            if (er !== e.err) begin
                errors++; $display("FAIL ls_err[%0d]: got %b expected %b", i, er, e.err);
            end
        end
    endtask

    task automatic test_errors();
        vec_t tbl [$];
        exp_t e;
        int lat;
        logic [31:0] rd;
        logic er;
        tbl.push_back(mk(1'b0, 3'd2, 32'h12, 32'h0, 32'h0, 1'b1));
        tbl.push_back(mk(1'b1, 3'd1, 32'h13, 32'h00001111, 32'h0, 1'b1));
        tbl.push_back(mk(1'b0, 3'd1, 32'h11, 32'h0, 32'h0, 1'b1));
        tbl.push_back(mk(1'b0, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1));
        tbl.push_back(mk(1'b1, 3'd3, 32'h10, 32'h0, 32'h0, 1'b1));
        tbl.push_back(mk(1'b1, 3'd4, 32'h10, 32'h00000077, 32'h0, 1'b1));
        tbl.push_back(mk(1'b1, 3'd2, 32'h800, 32'h11223344, 32'h0, 1'b1));
        tbl.push_back(mk(1'b0, 3'd2, 32'h800, 32'h0, 32'h0, 1'b1));
        tbl.push_back(mk(1'b1, 3'd2, 32'h7FC, 32'hA5A5A5A5, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 3'd2, 32'h7FC, 32'h0, 32'hA5A5A5A5, 1'b0));
        tbl.push_back(mk(1'b0, 3'd6, 32'h7FC, 32'h0, 32'h0, 1'b1));
        tbl.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0, 32'hCAFEAAEF, 1'b0));
        foreach (tbl[i]) begin
            e.rdata = tbl[i].rdata;
            e.err   = tbl[i].err;
            sb.push_back(e);
            drive_access(0, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata, lat, rd, er);
            e = sb.pop_front();
            checks++;
            if (lat !== 2) begin
                errors++; $display("FAIL err_latency[%0d]: got %0d expected 2", i, lat);
            end
            checks++;
            if (rd !== e.rdata) begin
                errors++; $display("FAIL err_rdata[%0d]: got %h expected %h", i, rd, e.rdata);
            end
            checks++;
            if (er !== e.err) begin
                errors++; $display("FAIL err_flag[%0d]: got %b expected %b", i, er, e.err);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int lat;
        logic [31:0] rd;
        logic er;
        e.rdata = 32'hCAFEAAEF;
        e.err   = 1'b0;
        sb.push_back(e);
        rsp_ready = 1'b0;
        drive_access(0, 1'b0, 3'd2, 32'h10, 32'h0, lat, rd, er);
        e = sb.pop_front();
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL bp_latency: got %0d expected 2", lat);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid_a[0] !== 1'b1 || rsp_rdata_a[0] !== e.rdata || rsp_err_a[0] !== e.err) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h err=%b expected valid=1 rdata=%h err=%b",
                         c, rsp_valid_a[0], rsp_rdata_a[0], rsp_err_a[0], e.rdata, e.err);
            end
            checks++;
            if (req_ready_a[0] !== 1'b0) begin
                errors++; $display("FAIL bp_req_ready[%0d]: got %b expected 0", c, req_ready_a[0]);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid_a[0] !== 1'b0 || rsp_rdata_a[0] !== 32'h0 || rsp_err_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got valid=%b rdata=%h err=%b expected 0/0/0",
                     rsp_valid_a[0], rsp_rdata_a[0], rsp_err_a[0]);
        end
        checks++;
        if (req_ready_a[0] !== 1'b1) begin
            errors++; $display("FAIL bp_ready_after: got %b expected 1", req_ready_a[0]);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int n;
        logic [31:0] rd;
        logic er;
        drive_access(1, 1'b1, 3'd2, 32'h20, 32'hCAFEF00D, lat, rd, er);
        checks++;
        if (lat !== 3 || er !== 1'b0) begin
            errors++; $display("FAIL rm_prefill: got lat=%0d err=%b expected lat=3 err=0", lat, er);
        end

        // reset one edge after accept: dropped in WAIT
        @(negedge clk);
        req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h12345678;
        req_valid_a[1] = 1'b1;
        n = 0;
        while (req_ready_a[1] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid_a[1] = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (req_ready_a[1] !== 1'b0 || rsp_valid_a[1] !== 1'b0) begin
                errors++; $display("FAIL rm_during_reset[%0d]: got ready=%b valid=%b expected 0/0",
                                   c, req_ready_a[1], rsp_valid_a[1]);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready_a[1] !== 1'b1) begin
            errors++; $display("FAIL rm_ready_after: got %b expected 1", req_ready_a[1]);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid_a[1] !== 1'b0) begin
                errors++; $display("FAIL rm_no_rsp[%0d]: got %b expected 0", c, rsp_valid_a[1]);
            end
        end

        // reset on the commit edge (accept N, commit N+3): no write
        @(negedge clk);
        req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h55555555;
        req_valid_a[1] = 1'b1;
        n = 0;
        while (req_ready_a[1] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid_a[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (rsp_valid_a[1] !== 1'b0) begin
            errors++; $display("FAIL rm_commit_reset_valid: got %b expected 0", rsp_valid_a[1]);
        end

        drive_access(1, 1'b0, 3'd2, 32'h20, 32'h0, lat, rd, er);
        checks++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            errors++; $display("FAIL rm_storage: got %h err=%b expected cafef00d err=0", rd, er);
        end
        checks++;
        if (lat !== 3) begin
            errors++; $display("FAIL rm_latency: got %0d expected 3", lat);
        end
    endtask

    // With LATENCY=1: accept N, rsp_valid after N+1, handshake N+2, next accept N+3.
    task automatic test_back_to_back();
        int lat;
        logic [31:0] rd;
        logic er;
        exp_t e;
        int acc, got, cyc;
        int acc_cyc [4];
        int rsp_cyc [4];
        logic rr;
        for (int i = 0; i < 4; i++) begin
            drive_access(2, 1'b1, 3'd2, 32'(4 * i), 32'hC0DE0000 + 32'(i), lat, rd, er);
            checks++;
            if (lat !== 1 || er !== 1'b0) begin
                errors++; $display("FAIL b2b_store[%0d]: got lat=%0d err=%b expected lat=1 err=0", i, lat, er);
            end
        end
        acc = 0; got = 0; cyc = 0;
        while (got < 4 && cyc < 60) begin
            @(negedge clk);
            if (acc < 4) begin
                req_write = 1'b0; req_funct3 = 3'd2; req_addr = 32'(4 * acc);
                req_valid_a[2] = 1'b1;
            end else begin
                req_valid_a[2] = 1'b0;
            end
            rr = req_ready_a[2] && req_valid_a[2];
            @(posedge clk);
            cyc++;
            if (rr) begin
                acc_cyc[acc] = cyc;
                e.rdata = 32'hC0DE0000 + 32'(acc);
                e.err   = 1'b0;
                sb.push_back(e);
                acc++;
            end
            #1;
            if (rsp_valid_a[2] === 1'b1) begin
                checks++;
                if (sb.size() == 0 || got >= 4) begin
                    errors++; $display("FAIL b2b_spurious: got rsp at cycle %0d expected none", cyc);
                end else begin
                    rsp_cyc[got] = cyc;
                    e = sb.pop_front();
                    if (rsp_rdata_a[2] !== e.rdata || rsp_err_a[2] !== e.err) begin
                        errors++; $display("FAIL b2b_data[%0d]: got %h err=%b expected %h err=%b",
                                           got, rsp_rdata_a[2], rsp_err_a[2], e.rdata, e.err);
                    end
                    got++;
                end
            end
        end
        req_valid_a[2] = 1'b0;
        checks++;
        if (got != 4) begin
            errors++; $display("FAIL b2b_count: got %0d responses expected 4", got);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rsp_cyc[i] - acc_cyc[i] != 1) begin
                    errors++; $display("FAIL b2b_latency[%0d]: got %0d expected 1", i, rsp_cyc[i] - acc_cyc[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
                        errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected 3",
                                           i, acc_cyc[i] - acc_cyc[i-1]);
                    end
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_store();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
